// File: rtl/fir_out_capture.sv
// Captures a rounded, scaled and saturated FIR output stream into a result buffer
// that the host can read back by address once the capture is done.
module fir_out_capture #(
  parameter int DEPTH = 128,
  parameter int IN_W  = 54,
  parameter int OUT_W = 18,
  parameter int SHIFT = 8,
  localparam int ADR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic [ADR_W-1:0]        len,
  input  logic signed [IN_W-1:0]  din,
  input  logic                    din_valid,
  input  logic                    rd_en,
  input  logic [ADR_W-1:0]        rd_adr,
  output logic signed [OUT_W-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    sat_flag,
  output logic [ADR_W:0]          wr_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  localparam logic signed [IN_W:0] RND =
    (SHIFT == 0) ? '0 : ((IN_W+1)'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));
  localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;
  localparam logic [ADR_W:0]       CNT_ONE = (ADR_W+1)'(1);

  // Returns {clipped, value}; the extra headroom bit keeps the rounding add exact.
  function automatic logic [OUT_W:0] scale_sat(input logic signed [IN_W-1:0] x);
    logic signed [IN_W:0] t;
    t = $signed({x[IN_W-1], x}) + RND;
    t = t >>> SHIFT;
    if (t > SAT_MAX)      return {1'b1, SAT_MAX[OUT_W-1:0]};
    else if (t < SAT_MIN) return {1'b1, SAT_MIN[OUT_W-1:0]};
    else                  return {1'b0, t[OUT_W-1:0]};
  endfunction

  state_t                  state_q, state_d;
  logic [ADR_W-1:0]        len_q;
  logic [ADR_W:0]          wr_cnt_q;
  logic [ADR_W:0]          acc_cnt_q;
  logic                    sat_q;
  logic                    vld_p0;
  logic signed [OUT_W-1:0] data_p0;
  logic                    sat_p0;
  logic signed [OUT_W-1:0] rd_data_q;
  logic                    rd_valid_q;
  logic [OUT_W:0]          scaled;
  logic                    start, last_wr, accept;
  logic signed [OUT_W-1:0] mem [DEPTH];

  assign scaled = scale_sat(din);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    last_wr = 1'b0;
    // Stop accepting once len+1 samples are in flight so late valids never reach the buffer.
    accept  = (state_q == S_CAPTURE) && din_valid && (acc_cnt_q <= {1'b0, len_q});
    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          state_d = S_CAPTURE;
          start   = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (vld_p0 && (wr_cnt_q[ADR_W-1:0] == len_q)) begin
          last_wr = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      wr_cnt_q   <= '0;
      acc_cnt_q  <= '0;
      sat_q      <= 1'b0;
      vld_p0     <= 1'b0;
      data_p0    <= '0;
      sat_p0     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Stage p0: scaled sample registered, written to the buffer on the next edge.
      vld_p0  <= accept;
      data_p0 <= scaled[OUT_W-1:0];
      sat_p0  <= accept & scaled[OUT_W];
      if (start) begin
        len_q     <= len;
        wr_cnt_q  <= '0;
        acc_cnt_q <= '0;
        sat_q     <= 1'b0;
      end else begin
        if (accept) acc_cnt_q <= acc_cnt_q + CNT_ONE;
        if (vld_p0) wr_cnt_q  <= wr_cnt_q + CNT_ONE;
        sat_q <= sat_q | sat_p0;
      end
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= mem[rd_adr];
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0 && (state_q == S_CAPTURE)) mem[wr_cnt_q[ADR_W-1:0]] <= data_p0;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == S_CAPTURE);
  assign done     = (state_q == S_DONE);
  assign sat_flag = sat_q;
  assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_fir_out_capture.sv
// Scenario bench for fir_out_capture: expected buffer contents are queued as samples are
// driven and popped when the buffer is read back.
module tb_fir_out_capture;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               arm = 1'b0;
  logic [6:0]         len = '0;
  logic signed [53:0] din = '0;
  logic               din_valid = 1'b0;
  logic               rd_en = 1'b0;
  logic [6:0]         rd_adr = '0;
  logic signed [17:0] rd_data;
  logic               rd_valid;
  logic               busy;
  logic               done;
  logic               sat_flag;
  logic [7:0]         wr_cnt;

  int checks = 0;
  int errors = 0;
  logic signed [17:0] exp_q[$];
  logic signed [17:0] old0;

  fir_out_capture dut (
    .clk(clk), .rst(rst), .arm(arm), .len(len), .din(din), .din_valid(din_valid),
    .rd_en(rd_en), .rd_adr(rd_adr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .sat_flag(sat_flag), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic signed [17:0] model(input longint d);
    longint t;
    t = (d + 128) >>> 8;
    if (t > 131071) t = 131071;
    if (t < -131072) t = -131072;
    return 18'(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_cap(input int l);
    arm = 1'b1;
    len = 7'(l);
    tick();
    arm = 1'b0;
  endtask

  task automatic send(input longint d);
    din = 54'(d);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, n);
    end
  endtask

  task automatic read_word(input int a, output logic signed [17:0] d, output logic v);
    rd_en = 1'b1;
    rd_adr = 7'(a);
    tick();
    rd_en = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({busy, done, sat_flag, rd_valid} !== 4'b0000 || wr_cnt !== 8'd0 || rd_data !== 18'sd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b sat=%b rv=%b wr_cnt=%0d rd=%0d, required all 0",
               busy, done, sat_flag, rd_valid, wr_cnt, rd_data);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic signed [17:0] d, e;
    logic v;
    arm_cap(3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: busy=%b, required 1", busy);
    end
    send(256);  exp_q.push_back(18'sd1);
    send(512);  exp_q.push_back(18'sd2);
    send(-256); exp_q.push_back(-18'sd1);
    send(1000); exp_q.push_back(18'sd4);
    wait_done("basic");
    checks++;
    if (busy !== 1'b0 || wr_cnt !== 8'd4 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: busy=%b wr_cnt=%0d sat=%b, required 0/4/0", busy, wr_cnt, sat_flag);
    end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      read_word(i, d, v);
      checks++;
      if (d !== e || v !== 1'b1) begin
        errors++;
        $display("FAIL basic_buf%0d: got %0d vld=%b, required %0d vld=1", i, d, v, e);
      end
    end
  endtask

  task automatic test_rounding();
    logic signed [17:0] d, e;
    logic v;
    arm_cap(3);
    send(128);  exp_q.push_back(18'sd1);
    send(127);  exp_q.push_back(18'sd0);
    send(-128); exp_q.push_back(18'sd0);
    send(-129); exp_q.push_back(-18'sd1);
    wait_done("round");
    checks++;
    if (sat_flag !== 1'b0 || wr_cnt !== 8'd4) begin
      errors++;
      $display("FAIL round_status: sat=%b wr_cnt=%0d, required 0/4", sat_flag, wr_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      read_word(i, d, v);
      checks++;
      if (d !== e || v !== 1'b1) begin
        errors++;
        $display("FAIL round_buf%0d: got %0d vld=%b, required %0d vld=1", i, d, v, e);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [17:0] d, e;
    logic v;
    arm_cap(1);
    send(longint'(1) << 40);   exp_q.push_back(18'sd131071);
    send(-(longint'(1) << 40)); exp_q.push_back(-18'sd131072);
    wait_done("sat");
    checks++;
    if (sat_flag !== 1'b1) begin
      errors++;
      $display("FAIL sat_flag_set: sat=%b, required 1", sat_flag);
    end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      read_word(i, d, v);
      checks++;
      if (d !== e || v !== 1'b1) begin
        errors++;
        $display("FAIL sat_buf%0d: got %0d vld=%b, required %0d vld=1", i, d, v, e);
      end
    end
    checks++;
    if (sat_flag !== 1'b1) begin
      errors++;
      $display("FAIL sat_flag_sticky: sat=%b, required 1", sat_flag);
    end
  endtask

  task automatic test_gapped();
    logic signed [17:0] d, e;
    logic v;
    longint s;
    arm_cap(4);
    checks++;
    if (sat_flag !== 1'b0 || done !== 1'b0 || wr_cnt !== 8'd0) begin
      errors++;
      $display("FAIL gap_arm_clear: sat=%b done=%b wr_cnt=%0d, required 0/0/0", sat_flag, done, wr_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      s = longint'($urandom_range(0, 2000000)) - 1000000;
      send(s);
      exp_q.push_back(model(s));
      if (i == 1) arm = 1'b1;
      len = 7'd9;
      tick();
      arm = 1'b0;
      tick();
    end
    wait_done("gap");
    for (int i = 0; i < 5; i++) send(longint'(i) * 5000 + 777);
    tick();
    checks++;
    if (wr_cnt !== 8'd5 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL gap_status: wr_cnt=%0d done=%b busy=%b, required 5/1/0", wr_cnt, done, busy);
    end
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      read_word(i, d, v);
      checks++;
      if (d !== e || v !== 1'b1) begin
        errors++;
        $display("FAIL gap_buf%0d: got %0d vld=%b, required %0d vld=1", i, d, v, e);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic signed [17:0] d, e;
    logic v;
    arm_cap(7);
    send(3000);
    send(-7000);
    tick();
    checks++;
    if (wr_cnt !== 8'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: wr_cnt=%0d busy=%b, required 2/1", wr_cnt, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_cnt !== 8'd0) begin
      errors++;
      $display("FAIL abort_async: busy=%b done=%b wr_cnt=%0d, required 0/0/0", busy, done, wr_cnt);
    end
    tick();
    rst = 1'b1;
    tick();
    arm_cap(1);
    send(51200);  exp_q.push_back(model(51200));
    send(-25700); exp_q.push_back(model(-25700));
    old0 = model(51200);
    wait_done("abort");
    checks++;
    if (wr_cnt !== 8'd2) begin
      errors++;
      $display("FAIL abort_rearm_cnt: wr_cnt=%0d, required 2", wr_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      read_word(i, d, v);
      checks++;
      if (d !== e || v !== 1'b1) begin
        errors++;
        $display("FAIL abort_buf%0d: got %0d vld=%b, required %0d vld=1", i, d, v, e);
      end
    end
  endtask

  task automatic test_collision();
    logic signed [17:0] d;
    logic v;
    arm_cap(0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL coll_arm: done=%b busy=%b, required 0/1", done, busy);
    end
    din = 54'(-99999);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    rd_en = 1'b1;
    rd_adr = 7'd0;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_data !== old0 || rd_valid !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL coll_read_first: rd=%0d rv=%b done=%b, required %0d/1/1", rd_data, rd_valid, done, old0);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== old0) begin
      errors++;
      $display("FAIL coll_pulse: rv=%b rd=%0d, required 0/%0d", rd_valid, rd_data, old0);
    end
    read_word(0, d, v);
    checks++;
    if (d !== model(-99999) || v !== 1'b1) begin
      errors++;
      $display("FAIL coll_new: got %0d vld=%b, required %0d vld=1", d, v, model(-99999));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_gapped();
    test_reset_abort();
    test_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
